// File: rtl/mem_req_sched.sv
// rtl/mem_req_sched.sv - single-port memory request sequencer with in-order store buffer and RAW blocking
module mem_req_sched #(
    parameter int WORD_W   = 32,
    parameter int OP_W     = 4,
    parameter int PDST_W   = 5,
    parameter int SB_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ld_req_valid,
    input  logic [OP_W-1:0]               ld_req_op,
    input  logic [WORD_W-1:0]             ld_req_imm,
    input  logic [WORD_W-1:0]             ld_req_rs1,
    input  logic [PDST_W-1:0]             ld_req_pdst,
    output logic                          ld_req_ready,
    input  logic                          st_push_valid,
    input  logic [OP_W-1:0]               st_push_op,
    input  logic [WORD_W-1:0]             st_push_addr,
    input  logic [WORD_W-1:0]             st_push_data,
    output logic                          st_push_ready,
    input  logic                          mem_ready,
    input  logic [3:0]                    mem_exp_code,
    input  logic                          load_data_valid,
    input  logic                          store_finish,
    output logic                          mem_issue_en,
    output logic [OP_W-1:0]               mem_issue_op,
    output logic [WORD_W-1:0]             mem_issue_imm,
    output logic [WORD_W-1:0]             mem_issue_rs1,
    output logic [WORD_W-1:0]             mem_issue_rs2,
    output logic [PDST_W-1:0]             mem_issue_pdst,
    output logic                          exp_valid,
    output logic                          exp_is_store,
    output logic [PDST_W-1:0]             exp_pdst,
    output logic [$clog2(SB_DEPTH):0]     sb_count,
    output logic                          sb_empty
);

    localparam int SB_AW = $clog2(SB_DEPTH);
    localparam int CNT_W = SB_AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT_LD, WAIT_ST} state_t;

    state_t              r_state;
    logic [OP_W-1:0]     r_sb_op   [SB_DEPTH];
    logic [WORD_W-1:0]   r_sb_addr [SB_DEPTH];
    logic [WORD_W-1:0]   r_sb_data [SB_DEPTH];
    logic [SB_DEPTH-1:0] r_sb_valid;
    logic [SB_AW-1:0]    r_wptr;
    logic [SB_AW-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_exp_valid;
    logic                r_exp_is_store;
    logic [PDST_W-1:0]   r_exp_pdst;

    logic [WORD_W-1:0]   w_ld_addr;
    logic                w_unused_addr_lsb;
    logic                w_hazard;
    logic                w_full;
    logic                w_empty;
    logic                w_idle_ok;
    logic                w_ld_ok;
    logic                w_grant_ld;
    logic                w_grant_st;
    logic                w_issue;
    logic                w_fault;
    logic                w_push;

    assign w_ld_addr         = ld_req_imm + ld_req_rs1;
    assign w_unused_addr_lsb = ^w_ld_addr[1:0];

    // Word-granular match against every live entry; loads never bypass a pending store.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (r_sb_valid[i] && (r_sb_addr[i][WORD_W-1:2] == w_ld_addr[WORD_W-1:2])) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign w_full     = (r_count == CNT_W'(SB_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_idle_ok  = rst_n && (r_state == IDLE) && mem_ready;
    assign w_ld_ok    = ld_req_valid && !w_hazard;
    assign w_grant_ld = w_idle_ok && !w_full && w_ld_ok;
    assign w_grant_st = w_idle_ok && (w_full || (!w_ld_ok && !w_empty));
    assign w_issue    = w_grant_ld || w_grant_st;
    assign w_fault    = w_issue && (mem_exp_code != 4'd0);

    // Full-check uses the registered count only, so a same-cycle pop never frees a slot.
    assign st_push_ready = !w_full;
    assign w_push        = st_push_valid && st_push_ready;

    assign ld_req_ready = w_grant_ld;
    assign mem_issue_en = w_issue;

    always_comb begin
        mem_issue_op   = '0;
        mem_issue_imm  = '0;
        mem_issue_rs1  = '0;
        mem_issue_rs2  = '0;
        mem_issue_pdst = '0;
        if (w_grant_ld) begin
            mem_issue_op   = ld_req_op;
            mem_issue_imm  = ld_req_imm;
            mem_issue_rs1  = ld_req_rs1;
            mem_issue_pdst = ld_req_pdst;
        end else if (w_grant_st) begin
            mem_issue_op  = r_sb_op[r_rptr];
            mem_issue_rs1 = r_sb_addr[r_rptr];
            mem_issue_rs2 = r_sb_data[r_rptr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sb_op[r_wptr]   <= st_push_op;
            r_sb_addr[r_wptr] <= st_push_addr;
            r_sb_data[r_wptr] <= st_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb_valid <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_sb_valid[r_wptr] <= 1'b1;
                r_wptr             <= r_wptr + SB_AW'(1);
            end
            if (w_grant_st) begin
                r_sb_valid[r_rptr] <= 1'b0;
                r_rptr             <= r_rptr + SB_AW'(1);
            end
            case ({w_push, w_grant_st})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_exp_valid    <= 1'b0;
            r_exp_is_store <= 1'b0;
            r_exp_pdst     <= '0;
        end else begin
            r_exp_valid    <= w_fault;
            r_exp_is_store <= w_fault && w_grant_st;
            r_exp_pdst     <= (w_fault && w_grant_ld) ? ld_req_pdst : '0;
            case (r_state)
                IDLE: begin
                    // A faulted issue never reaches mem_ctrl's completion path.
                    if (w_issue && !w_fault) begin
                        r_state <= w_grant_ld ? WAIT_LD : WAIT_ST;
                    end
                end
                WAIT_LD: if (load_data_valid) r_state <= IDLE;
                WAIT_ST: if (store_finish)    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign exp_valid    = r_exp_valid;
    assign exp_is_store = r_exp_is_store;
    assign exp_pdst     = r_exp_pdst;
    assign sb_count     = r_count;
    assign sb_empty     = w_empty;

endmodule

// File: tb/tb_mem_req_sched.sv
// tb/tb_mem_req_sched.sv - directed bench with issue scoreboard for mem_req_sched
module tb_mem_req_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_req_valid;
    logic [3:0]  ld_req_op;
    logic [31:0] ld_req_imm;
    logic [31:0] ld_req_rs1;
    logic [4:0]  ld_req_pdst;
    logic        ld_req_ready;
    logic        st_push_valid;
    logic [3:0]  st_push_op;
    logic [31:0] st_push_addr;
    logic [31:0] st_push_data;
    logic        st_push_ready;
    logic        mem_ready;
    logic [3:0]  mem_exp_code;
    logic        load_data_valid;
    logic        store_finish;
    logic        mem_issue_en;
    logic [3:0]  mem_issue_op;
    logic [31:0] mem_issue_imm;
    logic [31:0] mem_issue_rs1;
    logic [31:0] mem_issue_rs2;
    logic [4:0]  mem_issue_pdst;
    logic        exp_valid;
    logic        exp_is_store;
    logic [4:0]  exp_pdst;
    logic [2:0]  sb_count;
    logic        sb_empty;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  pdst;
    } iss_t;

    iss_t exq[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [3:0] OP_LW = 4'h2;
    localparam logic [3:0] OP_SW = 4'h8;

    mem_req_sched dut (
        .clk(clk), .rst_n(rst_n),
        .ld_req_valid(ld_req_valid), .ld_req_op(ld_req_op), .ld_req_imm(ld_req_imm),
        .ld_req_rs1(ld_req_rs1), .ld_req_pdst(ld_req_pdst), .ld_req_ready(ld_req_ready),
        .st_push_valid(st_push_valid), .st_push_op(st_push_op), .st_push_addr(st_push_addr),
        .st_push_data(st_push_data), .st_push_ready(st_push_ready),
        .mem_ready(mem_ready), .mem_exp_code(mem_exp_code),
        .load_data_valid(load_data_valid), .store_finish(store_finish),
        .mem_issue_en(mem_issue_en), .mem_issue_op(mem_issue_op), .mem_issue_imm(mem_issue_imm),
        .mem_issue_rs1(mem_issue_rs1), .mem_issue_rs2(mem_issue_rs2), .mem_issue_pdst(mem_issue_pdst),
        .exp_valid(exp_valid), .exp_is_store(exp_is_store), .exp_pdst(exp_pdst),
        .sb_count(sb_count), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every issue pops the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_issue_en) begin
                total++;
                if (exq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_issue op=%h imm=%h rs1=%h rs2=%h pdst=%0d",
                             mem_issue_op, mem_issue_imm, mem_issue_rs1, mem_issue_rs2, mem_issue_pdst);
                end else begin
                    iss_t e;
                    iss_t a;
                    e = exq.pop_front();
                    a = '{op: mem_issue_op, imm: mem_issue_imm, rs1: mem_issue_rs1,
                          rs2: mem_issue_rs2, pdst: mem_issue_pdst};
                    if (a !== e) begin
                        bad++;
                        $display("FAIL issue_fields got op=%h imm=%h rs1=%h rs2=%h pdst=%0d want op=%h imm=%h rs1=%h rs2=%h pdst=%0d",
                                 a.op, a.imm, a.rs1, a.rs2, a.pdst, e.op, e.imm, e.rs1, e.rs2, e.pdst);
                    end
                end
            end else begin
                total++;
                if ({mem_issue_op, mem_issue_imm, mem_issue_rs1, mem_issue_rs2, mem_issue_pdst} !== '0) begin
                    bad++;
                    $display("FAIL idle_outputs_zero got op=%h imm=%h rs1=%h rs2=%h pdst=%0d want all 0",
                             mem_issue_op, mem_issue_imm, mem_issue_rs1, mem_issue_rs2, mem_issue_pdst);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic exp_ld(input logic [31:0] imm, input logic [31:0] rs1, input logic [4:0] pdst);
        exq.push_back('{op: OP_LW, imm: imm, rs1: rs1, rs2: 32'h0, pdst: pdst});
    endtask

    task automatic exp_st(input logic [31:0] addr, input logic [31:0] data);
        exq.push_back('{op: OP_SW, imm: 32'h0, rs1: addr, rs2: data, pdst: 5'd0});
    endtask

    task automatic set_ld(input logic v, input logic [31:0] imm, input logic [31:0] rs1, input logic [4:0] pdst);
        ld_req_valid = v;
        ld_req_op    = OP_LW;
        ld_req_imm   = imm;
        ld_req_rs1   = rs1;
        ld_req_pdst  = pdst;
    endtask

    task automatic set_st(input logic v, input logic [31:0] addr, input logic [31:0] data);
        st_push_valid = v;
        st_push_op    = OP_SW;
        st_push_addr  = addr;
        st_push_data  = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_ld(1'b1, 32'h4, 32'h100, 5'd3);
        set_st(1'b0, 32'h0, 32'h0);
        mem_ready = 1'b1; mem_exp_code = 4'd0;
        load_data_valid = 1'b0; store_finish = 1'b0;

        // Reset state, with a load and mem_ready asserted during reset
        neg();
        chk("rst_sb_count", 32'(sb_count), 32'd0);
        chk("rst_sb_empty", 32'(sb_empty), 32'd1);
        chk("rst_push_ready", 32'(st_push_ready), 32'd1);
        chk("rst_exp_valid", 32'(exp_valid), 32'd0);
        chk("rst_issue_en", 32'(mem_issue_en), 32'd0);
        chk("rst_ld_ready", 32'(ld_req_ready), 32'd0);
        nxt();
        rst_n = 1'b1;

        // Load only, then back-to-back load gated by completion
        exp_ld(32'h4, 32'h100, 5'd3);
        neg(); chk("ld1_ready", 32'(ld_req_ready), 32'd1);
        nxt(); set_ld(1'b1, 32'h8, 32'h100, 5'd4);
        for (int i = 0; i < 3; i++) begin
            neg(); chk("ld_wait_ready", 32'(ld_req_ready), 32'd0);
            nxt();
        end
        load_data_valid = 1'b1;
        neg(); chk("ld_cmpl_cycle_ready", 32'(ld_req_ready), 32'd0);
        nxt(); load_data_valid = 1'b0; exp_ld(32'h8, 32'h100, 5'd4);
        neg(); chk("ld2_ready", 32'(ld_req_ready), 32'd1);
        nxt(); ld_req_valid = 1'b0; load_data_valid = 1'b1;
        neg(); nxt(); load_data_valid = 1'b0;

        // Store drain and mismatched completion ignored in WAIT_ST
        mem_ready = 1'b0; set_st(1'b1, 32'h200, 32'hDEADBEEF);
        neg(); nxt(); st_push_valid = 1'b0;
        neg(); chk("st_count_1", 32'(sb_count), 32'd1); chk("st_not_empty", 32'(sb_empty), 32'd0);
        nxt(); mem_ready = 1'b1; exp_st(32'h200, 32'hDEADBEEF);
        neg(); nxt();
        neg(); chk("st_count_0", 32'(sb_count), 32'd0);
        nxt(); set_ld(1'b1, 32'h0, 32'h500, 5'd6); load_data_valid = 1'b1;
        neg(); chk("wst_ld_ready_a", 32'(ld_req_ready), 32'd0);
        nxt(); load_data_valid = 1'b0;
        neg(); chk("wst_ignore_ldv", 32'(ld_req_ready), 32'd0);
        nxt(); store_finish = 1'b1;
        neg(); nxt(); store_finish = 1'b0; exp_ld(32'h0, 32'h500, 5'd6);
        neg(); chk("after_st_ld_ready", 32'(ld_req_ready), 32'd1);
        nxt(); ld_req_valid = 1'b0; load_data_valid = 1'b1;
        neg(); nxt(); load_data_valid = 1'b0;

        // RAW hazard: same word, different byte offset
        mem_ready = 1'b0; set_st(1'b1, 32'h300, 32'h11);
        neg(); nxt(); st_push_valid = 1'b0;
        set_ld(1'b1, 32'h2, 32'h300, 5'd5); mem_ready = 1'b1;
        exp_st(32'h300, 32'h11);
        neg(); chk("haz_ld_blocked", 32'(ld_req_ready), 32'd0);
        nxt();
        neg(); chk("haz_wait_ready", 32'(ld_req_ready), 32'd0);
        nxt(); store_finish = 1'b1;
        neg(); chk("haz_fin_ready", 32'(ld_req_ready), 32'd0);
        nxt(); store_finish = 1'b0; exp_ld(32'h2, 32'h300, 5'd5);
        neg(); chk("haz_ld_go", 32'(ld_req_ready), 32'd1);
        nxt(); ld_req_valid = 1'b0; load_data_valid = 1'b1;
        neg(); nxt(); load_data_valid = 1'b0;

        // Full buffer takes priority; push rejected in the pop cycle
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_st(1'b1, 32'h400 + 32'(4 * i), 32'(i + 1));
            neg(); nxt();
        end
        st_push_valid = 1'b0;
        neg(); chk("full_count", 32'(sb_count), 32'd4); chk("full_push_ready", 32'(st_push_ready), 32'd0);
        nxt(); set_ld(1'b1, 32'h0, 32'h800, 5'd7); set_st(1'b1, 32'h500, 32'h5);
        mem_ready = 1'b1; exp_st(32'h400, 32'h1);
        neg(); chk("full_ld_ready", 32'(ld_req_ready), 32'd0); chk("full_pop_push_ready", 32'(st_push_ready), 32'd0);
        nxt(); st_push_valid = 1'b0;
        neg(); chk("full_reject_count", 32'(sb_count), 32'd3);
        nxt(); store_finish = 1'b1;
        neg(); nxt(); store_finish = 1'b0; exp_ld(32'h0, 32'h800, 5'd7);
        neg(); chk("full_ld_after", 32'(ld_req_ready), 32'd1);
        nxt(); ld_req_valid = 1'b0; load_data_valid = 1'b1;
        neg(); nxt(); load_data_valid = 1'b0;
        exp_st(32'h404, 32'h2); exp_st(32'h408, 32'h3); exp_st(32'h40C, 32'h4);
        store_finish = 1'b1;
        for (int i = 0; i < 6; i++) begin
            neg(); nxt();
        end
        store_finish = 1'b0;
        neg(); chk("drain_empty", 32'(sb_empty), 32'd1);
        nxt();

        // In-issue exceptions: store then load
        mem_ready = 1'b0; set_st(1'b1, 32'h600, 32'h66);
        neg(); nxt(); st_push_valid = 1'b0; mem_ready = 1'b1; mem_exp_code = 4'd6;
        exp_st(32'h600, 32'h66);
        neg(); nxt(); mem_exp_code = 4'd0; mem_ready = 1'b0;
        neg();
        chk("exc_st_valid", 32'(exp_valid), 32'd1);
        chk("exc_st_is_store", 32'(exp_is_store), 32'd1);
        chk("exc_st_pdst", 32'(exp_pdst), 32'd0);
        chk("exc_st_popped", 32'(sb_count), 32'd0);
        nxt(); set_ld(1'b1, 32'h0, 32'h700, 5'd9); mem_ready = 1'b1; mem_exp_code = 4'd4;
        exp_ld(32'h0, 32'h700, 5'd9);
        neg(); chk("exc_idle_ld_ready", 32'(ld_req_ready), 32'd1);
        nxt(); ld_req_valid = 1'b0; mem_exp_code = 4'd0; mem_ready = 1'b0;
        neg();
        chk("exc_ld_valid", 32'(exp_valid), 32'd1);
        chk("exc_ld_is_store", 32'(exp_is_store), 32'd0);
        chk("exc_ld_pdst", 32'(exp_pdst), 32'd9);
        nxt();
        neg(); chk("exc_pulse_end", 32'(exp_valid), 32'd0);
        nxt();

        // Reset while WAIT_LD with two stores buffered
        set_st(1'b1, 32'h900, 32'h9);
        neg(); nxt(); set_st(1'b1, 32'h904, 32'hA);
        neg(); nxt(); st_push_valid = 1'b0;
        set_ld(1'b1, 32'h0, 32'hA00, 5'd2); mem_ready = 1'b1; exp_ld(32'h0, 32'hA00, 5'd2);
        neg(); chk("pre_rst_ld_ready", 32'(ld_req_ready), 32'd1);
        nxt(); ld_req_valid = 1'b0; mem_ready = 1'b0;
        neg(); chk("pre_rst_count", 32'(sb_count), 32'd2);
        nxt(); rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(sb_count), 32'd0);
        chk("mid_rst_empty", 32'(sb_empty), 32'd1);
        neg(); nxt();
        rst_n = 1'b1; mem_ready = 1'b1; load_data_valid = 1'b1;
        set_ld(1'b1, 32'h0, 32'hB00, 5'd1); exp_ld(32'h0, 32'hB00, 5'd1);
        neg(); chk("post_rst_ld_ready", 32'(ld_req_ready), 32'd1);
        nxt(); load_data_valid = 1'b0; set_ld(1'b1, 32'h0, 32'hC00, 5'd8);
        neg(); chk("post_rst_wait_ld", 32'(ld_req_ready), 32'd0);
        nxt(); ld_req_valid = 1'b0; load_data_valid = 1'b1;
        neg(); chk("post_rst_empty", 32'(sb_empty), 32'd1);
        nxt(); load_data_valid = 1'b0;
        neg(); nxt();

        chk("queue_drained", 32'(exq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_req_sched.md
Name: mem_req_sched

Overview:
- Sequences all traffic into the single memory-unit port (mem_ctrl); exactly one transaction is in flight at a time.
- Arbitrates between speculative loads from the load issue queue and committed stores held in an internal in-order store buffer.
- Blocks any load whose word address matches a buffered store, so RAW ordering is preserved without forwarding.
- Sits between the load issue queue / ROB commit logic and mem_ctrl.

Parameters:
- WORD_W, 32, data/address width
- OP_W, 4, memory op code width (DATA_WIDTH_MEM_OP)
- PDST_W, 5, ROB index width (clog2(ROB_DEPTH))
- SB_DEPTH, 4, store buffer entries (power of two, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ld_req_valid  in  1  load request pending
- ld_req_op  in  OP_W  load op (LW/LH/LHU/LB/LBU)
- ld_req_imm  in  WORD_W  offset
- ld_req_rs1  in  WORD_W  base
- ld_req_pdst  in  PDST_W  ROB tag
- ld_req_ready  out  1  load accepted this cycle
- st_push_valid  in  1  committed store from ROB
- st_push_op  in  OP_W  SW/SH/SB
- st_push_addr  in  WORD_W  effective address
- st_push_data  in  WORD_W  store data
- st_push_ready  out  1  buffer can accept
- mem_ready  in  1  mem_ctrl can accept an issue
- mem_exp_code  in  4  mem_ctrl exception code, valid in the issue cycle; 0 = none
- load_data_valid  in  1  load completion from mem_ctrl
- store_finish  in  1  store completion from mem_ctrl
- mem_issue_en  out  1  issue pulse to mem_ctrl
- mem_issue_op  out  OP_W  op to mem_ctrl
- mem_issue_imm  out  WORD_W  offset
- mem_issue_rs1  out  WORD_W  base
- mem_issue_rs2  out  WORD_W  store data
- mem_issue_pdst  out  PDST_W  tag
- exp_valid  out  1  issued op faulted (registered pulse)
- exp_is_store  out  1  faulting op was a store
- exp_pdst  out  PDST_W  tag of faulting load (0 for stores)
- sb_count  out  clog2(SB_DEPTH)+1  buffer occupancy
- sb_empty  out  1  sb_count == 0

Behaviour:
- Reset values:
  - FSM in IDLE; sb_count = 0; sb_empty = 1; st_push_ready = 1.
  - exp_* = 0.
  - mem_issue_en and ld_req_ready forced to 0 while rst_n is low.
- Store buffer:
  - Circular FIFO; each entry holds {op, addr, data, valid}.
  - st_push_ready = (sb_count < SB_DEPTH), computed from the registered count only. A push while full is rejected even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - Read and write pointers wrap at SB_DEPTH.
- Hazard: a load is blocked when any valid entry has addr[WORD_W-1:2] == (ld_req_imm + ld_req_rs1)[WORD_W-1:2]. The sum is modulo 2^WORD_W. The check runs against all valid entries, including an entry pushed in the previous cycle.
- FSM states: IDLE, WAIT_LD, WAIT_ST.
- IDLE grant, evaluated combinationally when mem_ready = 1, in priority order:
  1. sb_count == SB_DEPTH: issue the head store.
  2. Otherwise, ld_req_valid and no hazard: issue the load; ld_req_ready = 1.
  3. Otherwise, sb not empty: issue the head store.
- No grant while mem_ready = 0.
- Issue cycle:
  - mem_issue_en = 1 for exactly one cycle.
  - Load issue: op/imm/rs1/pdst are passed through; rs2 = 0.
  - Store issue: op = entry op; imm = 0; rs1 = entry addr; rs2 = entry data; pdst = 0.
  - A store entry is popped in its issue cycle.
  - Next state is WAIT_LD or WAIT_ST.
- In-issue exception: if mem_exp_code != 0 in the issue cycle:
  - The next state is IDLE instead of a WAIT state.
  - The next cycle pulses exp_valid with exp_is_store and exp_pdst set.
  - A faulted store is still popped.
- WAIT_LD: returns to IDLE on load_data_valid. The next grant may occur in the cycle after completion (2-cycle minimum per op).
- WAIT_ST: returns to IDLE on store_finish.
- Completion pulses that do not match the WAIT state are ignored.
- All mem_issue_* outputs are 0 when mem_issue_en = 0.
- Reset mid-transaction:
  - The FSM returns to IDLE and the buffer is cleared.
  - Completions arriving after reset are ignored.

Test Plan:
- Load only: ld_req_valid, LW, imm=4, rs1=0x100, pdst=3, mem_ready=1 -> same cycle mem_issue_en=1, rs1=0x100, imm=4, ld_req_ready=1. Then no issue until load_data_valid, and the next issue no earlier than the cycle after it.
- Store drain: push SW addr=0x200 data=0xDEADBEEF, no loads -> issue with rs1=0x200, rs2=0xDEADBEEF, imm=0; sb_count 1->0 in the issue cycle; WAIT_ST until store_finish.
- Hazard: buffer holds SW addr=0x300; load with imm=2, rs1=0x300 -> store issues first. The load is issued only after store_finish, with ld_req_ready held 0 until then.
- Full priority: fill 4 stores with mem_ready=0, hold a non-hazard load valid, then raise mem_ready -> head store issues first. st_push_ready=0 while full, and a push is rejected in the pop cycle.
- Exception: issue a store with mem_exp_code=6 -> next cycle exp_valid=1, exp_is_store=1, FSM in IDLE, entry popped. A load with code 4 gives exp_pdst equal to the load's tag.
- Reset while in WAIT_LD with 2 stores buffered -> sb_count=0, sb_empty=1, and a following load_data_valid has no effect.
